// File: rtl/reflet_serial_io_expander.sv
// Bus-mapped driver for a 74HC595 output chain and a 74HC165 input chain
// sharing one serial clock; transfers are run by a small FSM.
module reflet_serial_io_expander #(
  parameter int base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 16'hFF26,
  parameter int chain_len = 16,
  parameter int clk_div = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  output logic                      sclk,
  output logic                      sdo,
  output logic                      latch,
  output logic                      load_n,
  input  logic                      sdi
);

  localparam int NB = chain_len / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(clk_div + 1);
  localparam int BW = $clog2(chain_len);
  localparam logic [CW-1:0] CMAX = CW'(clk_div - 1);
  localparam logic [BW-1:0] BMAX = BW'(chain_len - 1);
  localparam logic [8:0] NB9 = 9'(NB);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic phase, phase_n;
  logic sample, shift, finish, snap;

  logic [chain_len-1:0] shreg, shreg_n, capture, out_flat;
  logic [7:0] out_buf [NB];
  logic [7:0] in_buf [NB];
  logic [7:0] index;
  logic auto_en, done;

  logic [base_addr_size-1:0] offs;
  logic [1:0] off;
  logic sel, wr, wr_idx, wr_out, wr_ctl;
  logic in_range, busy, start;
  logic [IW-1:0] idx;

  assign offs = addr - base_addr;
  assign off = offs[1:0];
  assign sel = enable && (offs[base_addr_size-1:2] == '0);
  assign wr = sel && write_en;
  assign wr_idx = wr && (off == 2'd0);
  assign wr_out = wr && (off == 2'd1);
  assign wr_ctl = wr && (off == 2'd3);
  assign in_range = {1'b0, index} < NB9;
  assign idx = index[IW-1:0];
  assign busy = (state != IDLE);
  assign start = wr_ctl && data_in[0] && !busy;

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      out_flat[k*8 +: 8] = out_buf[k];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    phase_n = phase;
    bits_n = bits;
    sample = 1'b0;
    shift = 1'b0;
    finish = 1'b0;
    snap = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          cnt_n = '0;
          snap = 1'b1;
        end
      end
      LOAD: begin
        if (cnt == CMAX) begin
          state_n = SHIFT;
          cnt_n = '0;
          phase_n = 1'b0;
          bits_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CMAX) begin
          cnt_n = '0;
          phase_n = !phase;
          if (!phase) begin
            sample = 1'b1;
          end else begin
            shift = 1'b1;
            if (bits == BMAX) begin
              state_n = LATCH;
            end else begin
              bits_n = bits + 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LATCH: begin
        if (cnt == CMAX) begin
          cnt_n = '0;
          finish = 1'b1;
          if (auto_en) begin
            state_n = LOAD;
            snap = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (snap) begin
      shreg_n = out_flat;
    end else if (shift) begin
      shreg_n = {shreg[chain_len-2:0], 1'b0};
    end else begin
      shreg_n = shreg;
    end
  end

  // Pins are registered from next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      phase <= 1'b0;
      bits <= '0;
      shreg <= '0;
      capture <= '0;
      index <= '0;
      auto_en <= 1'b0;
      done <= 1'b0;
      sclk <= 1'b0;
      sdo <= 1'b0;
      latch <= 1'b0;
      load_n <= 1'b1;
      for (int k = 0; k < NB; k++) begin
        out_buf[k] <= '0;
        in_buf[k] <= '0;
      end
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      phase <= phase_n;
      bits <= bits_n;
      shreg <= shreg_n;
      sclk <= (state_n == SHIFT) && phase_n;
      sdo <= (state_n == SHIFT) && shreg_n[chain_len-1];
      latch <= (state_n == LATCH);
      load_n <= (state_n != LOAD);
      if (sample) begin
        capture <= {capture[chain_len-2:0], sdi};
      end
      if (finish) begin
        for (int k = 0; k < NB; k++) begin
          in_buf[k] <= capture[k*8 +: 8];
        end
      end
      if (wr_idx) begin
        index <= data_in;
      end
      if (wr_out && in_range) begin
        out_buf[idx] <= data_in;
      end
      if (wr_ctl) begin
        auto_en <= data_in[3];
      end
      if (finish) begin
        done <= 1'b1;
      end else if (wr_ctl && (data_in[2] || start)) begin
        done <= 1'b0;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      unique case (1'b1)
        (off == 2'd0): data_out = index;
        (off == 2'd1): data_out = in_range ? out_buf[idx] : 8'h00;
        (off == 2'd2): data_out = in_range ? in_buf[idx] : 8'h00;
        (off == 2'd3): data_out = {4'b0, auto_en, done, busy, 1'b0};
        default: data_out = '0;
      endcase
    end
  end

endmodule
